// File: rtl/i2c_reg_sequencer.sv
// Register-transaction sequencer for a byte-level I2C master: a write is addr+W, reg, data, STOP and a
// read is addr+W, reg, repeated START addr+R, one byte, STOP. One command at a time; one response each.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned CNT_W       = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rw,
  input  logic [6:0] i_cmd_dev_addr,
  input  logic [7:0] i_cmd_reg_addr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic [1:0] o_rsp_err,
  output logic       o_m_i2c_en,
  output logic       o_m_i2c_start,
  output logic       o_m_i2c_stop,
  output logic       o_m_i2c_rw,
  output logic [6:0] o_m_slave_addr,
  output logic [7:0] o_m_tx_data,
  input  logic [7:0] i_m_rx_data,
  input  logic       i_m_tx_done,
  input  logic       i_m_rx_done,
  input  logic       i_m_busy,
  input  logic       i_m_ack_error
);

  typedef enum logic [3:0] {
    StIdle, StSendReg, StWaitReg, StSendDat, StWaitDat,
    StRstart, StWaitRd, StStop, StWaitIdle, StResp
  } state_e;

  state_e           r_state;
  logic             r_rw;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rx;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_en;
  logic             r_start;
  logic             r_stop;
  logic             r_m_rw;
  logic [6:0]       r_slave_addr;
  logic [7:0]       r_tx_data;

  logic             w_tmo;
  logic [1:0]       w_err_tmo;
  logic [1:0]       w_err_nack;

  // Abort after TIMEOUT_CYC cycles spent in a wait state.
  assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_err_tmo  = (r_err == 2'b00) ? 2'b10 : r_err;
  assign w_err_nack = (r_err == 2'b00) ? 2'b01 : r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_rw         <= 1'b0;
      r_wdata      <= 8'h00;
      r_rx         <= 8'h00;
      r_err        <= 2'b00;
      r_cnt        <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 8'h00;
      r_en         <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_m_rw       <= 1'b0;
      r_slave_addr <= 7'h00;
      r_tx_data    <= 8'h00;
    end else begin
      r_en        <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= r_cnt + 1'b1;
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_cmd_ready  <= 1'b0;
            r_rw         <= i_cmd_rw;
            r_wdata      <= i_cmd_wdata;
            r_slave_addr <= i_cmd_dev_addr;
            r_tx_data    <= i_cmd_reg_addr;
            r_m_rw       <= 1'b0;
            r_err        <= 2'b00;
            r_en         <= 1'b1;
            r_state      <= StSendReg;
          end
        end
        StSendReg: begin
          r_cnt   <= '0;
          r_state <= StWaitReg;
        end
        StWaitReg: begin
          if (i_m_tx_done) begin
            if (i_m_ack_error) begin
              r_err   <= w_err_nack;
              r_stop  <= 1'b1;
              r_state <= StStop;
            end else if (r_rw) begin
              r_m_rw  <= 1'b1;
              r_start <= 1'b1;
              r_state <= StRstart;
            end else begin
              r_tx_data <= r_wdata;
              r_en      <= 1'b1;
              r_state   <= StSendDat;
            end
          end else if (w_tmo) begin
            r_err   <= w_err_tmo;
            r_stop  <= 1'b1;
            r_state <= StStop;
          end
        end
        StSendDat: begin
          r_cnt   <= '0;
          r_state <= StWaitDat;
        end
        StWaitDat: begin
          if (i_m_tx_done) begin
            if (i_m_ack_error) r_err <= w_err_nack;
            r_stop  <= 1'b1;
            r_state <= StStop;
          end else if (w_tmo) begin
            r_err   <= w_err_tmo;
            r_stop  <= 1'b1;
            r_state <= StStop;
          end
        end
        StRstart: begin
          r_cnt   <= '0;
          r_state <= StWaitRd;
        end
        StWaitRd: begin
          if (i_m_rx_done) begin
            r_rx    <= i_m_rx_data;
            r_stop  <= 1'b1;
            r_state <= StStop;
          end else if (w_tmo) begin
            r_err   <= w_err_tmo;
            r_stop  <= 1'b1;
            r_state <= StStop;
          end
        end
        StStop: begin
          r_cnt   <= '0;
          r_state <= StWaitIdle;
        end
        StWaitIdle: begin
          if (!i_m_busy) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_err == 2'b00 && r_rw) ? r_rx : 8'h00;
            r_state     <= StResp;
          end else if (w_tmo) begin
            r_err       <= w_err_tmo;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 8'h00;
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_rsp_rdata <= 8'h00;
          r_cmd_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_err      = r_err;
  assign o_m_i2c_en     = r_en;
  assign o_m_i2c_start  = r_start;
  assign o_m_i2c_stop   = r_stop;
  assign o_m_i2c_rw     = r_m_rw;
  assign o_m_slave_addr = r_slave_addr;
  assign o_m_tx_data    = r_tx_data;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural I2C master/slave model, negedge monitor and a response
// scoreboard (expected {err, rdata} queued at command issue, compared when the DUT responds).
module tb_i2c_reg_sequencer;
  localparam int unsigned Tmo = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev = 7'h00;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_en, m_start, m_stop, m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_tx;
  logic [7:0] m_rx_data = 8'h00;
  logic       m_tx_done = 1'b0;
  logic       m_rx_done = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_ack_error = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_CYC(Tmo), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
    .i_cmd_dev_addr(cmd_dev), .i_cmd_reg_addr(cmd_reg), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_m_i2c_en(m_en), .o_m_i2c_start(m_start), .o_m_i2c_stop(m_stop), .o_m_i2c_rw(m_rw),
    .o_m_slave_addr(m_addr), .o_m_tx_data(m_tx), .i_m_rx_data(m_rx_data),
    .i_m_tx_done(m_tx_done), .i_m_rx_done(m_rx_done), .i_m_busy(m_busy),
    .i_m_ack_error(m_ack_error)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master + single slave at slave_dev; silent suppresses every tx_done.
  logic       silent = 1'b0;
  logic [6:0] slave_dev = 7'h55;
  logic [7:0] slave_data = 8'h3C;
  int         tx_dly = 0, rx_dly = 0, stop_dly = 0;
  logic       pend_nack = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] slave_log[$];

  always @(posedge clk) begin
    m_tx_done   <= 1'b0;
    m_rx_done   <= 1'b0;
    m_ack_error <= 1'b0;
    if (!rst_n) begin
      m_busy   <= 1'b0;
      tx_dly   <= 0;
      rx_dly   <= 0;
      stop_dly <= 0;
    end else begin
      if (tx_dly == 1) begin
        m_tx_done   <= 1'b1;
        m_ack_error <= pend_nack;
        if (!pend_nack) slave_log.push_back(pend_byte);
      end
      if (rx_dly == 1) begin
        m_rx_done <= 1'b1;
        m_rx_data <= slave_data;
      end
      if (stop_dly == 1) m_busy <= 1'b0;
      tx_dly   <= (tx_dly > 0) ? tx_dly - 1 : 0;
      rx_dly   <= (rx_dly > 0) ? rx_dly - 1 : 0;
      stop_dly <= (stop_dly > 0) ? stop_dly - 1 : 0;
      if (m_en) begin
        m_busy <= 1'b1;
        if (!silent) begin
          tx_dly    <= 3;
          pend_nack <= (m_addr != slave_dev);
          pend_byte <= m_tx;
        end
      end
      if (m_start) rx_dly <= 3;
      if (m_stop) stop_dly <= 3;
    end
  end

  // Monitor
  int         en_n = 0, start_n = 0, stop_n = 0, en_cyc = 0, stop_cyc = 0;
  logic       start_rw = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] en_tx[$];
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int         rsp_cyc[$];
  int         acc_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_en) begin en_n <= en_n + 1; en_tx.push_back(m_tx); en_cyc <= cyc; end
      if (m_start) begin start_n <= start_n + 1; start_rw <= m_rw; end
      if (m_stop) begin stop_n <= stop_n + 1; stop_cyc <= cyc; end
      if (rsp_valid) begin obs_q.push_back({rsp_err, rsp_rdata}); rsp_cyc.push_back(cyc); end
      if (prev_ready && !cmd_ready) acc_cyc.push_back(cyc);
    end
    prev_ready <= cmd_ready;
  end

  task automatic clear_logs();
    @(negedge clk);
    en_n = 0; start_n = 0; stop_n = 0;
    en_tx.delete(); obs_q.delete(); exp_q.delete();
    rsp_cyc.delete(); acc_cyc.delete(); slave_log.delete();
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                       input logic [7:0] wd, input bit hold);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = ra; cmd_wdata = wd;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    // Scrambled fields must not affect the transaction in flight.
    cmd_rw = ~rw; cmd_dev = 7'h7F; cmd_reg = 8'hFF; cmd_wdata = 8'h00;
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output logic [9:0] got);
    int n = 0;
    while (obs_q.size() == 0 && n < budget) begin @(negedge clk); n++; end
    ok  = (obs_q.size() != 0);
    got = ok ? obs_q.pop_front() : 10'h3FF;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_en, m_start, m_stop, m_rw, m_addr, m_tx};
    total++;
    if (got !== {1'b1, 30'h0}) begin
      bad++; $display("FAIL reset_outputs: got %h required %h", got, {1'b1, 30'h0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write();
    bit ok; logic [9:0] got, exp;
    clear_logs();
    issue(1'b0, 7'h55, 8'h10, 8'hA5, 1'b0);
    exp_q.push_back({2'b00, 8'h00});
    wait_rsp(200, ok, got);
    exp = exp_q.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL write_rsp: got %h required %h", got, exp); end
    total++;
    if (en_n != 2 || en_tx.size() != 2) begin
      bad++; $display("FAIL write_en_count: got %0d required 2", en_n);
    end else begin
      total++;
      if (en_tx[0] !== 8'h10 || en_tx[1] !== 8'hA5) begin
        bad++; $display("FAIL write_en_tx: got %h,%h required 10,a5", en_tx[0], en_tx[1]);
      end
    end
    total++;
    if (stop_n != 1 || start_n != 0) begin
      bad++; $display("FAIL write_stop_start: got stop=%0d start=%0d required 1,0", stop_n, start_n);
    end
    total++;
    if (slave_log.size() != 2 || slave_log[0] !== 8'h10 || slave_log[1] !== 8'hA5) begin
      bad++; $display("FAIL write_slave_rx: got %0d bytes required 10,a5", slave_log.size());
    end
  endtask

  task automatic test_read();
    bit ok; logic [9:0] got, exp;
    clear_logs();
    issue(1'b1, 7'h55, 8'h20, 8'h99, 1'b0);
    exp_q.push_back({2'b00, 8'h3C});
    wait_rsp(200, ok, got);
    exp = exp_q.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL read_rsp: got %h required %h", got, exp); end
    total++;
    if (en_n != 1 || start_n != 1 || stop_n != 1 || start_rw !== 1'b1) begin
      bad++;
      $display("FAIL read_pulses: got en=%0d start=%0d stop=%0d rw=%b required 1,1,1,1",
               en_n, start_n, stop_n, start_rw);
    end
    total++;
    if (en_tx.size() != 1 || en_tx[0] !== 8'h20) begin
      bad++; $display("FAIL read_reg_byte: got %0d entries required one 20", en_tx.size());
    end
  endtask

  task automatic test_nack();
    bit ok; logic [9:0] got, exp;
    clear_logs();
    issue(1'b0, 7'h33, 8'h10, 8'hA5, 1'b0);
    exp_q.push_back({2'b01, 8'h00});
    wait_rsp(200, ok, got);
    exp = exp_q.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL nack_rsp: got %h required %h", got, exp); end
    total++;
    if (en_n != 1 || stop_n != 1) begin
      bad++; $display("FAIL nack_pulses: got en=%0d stop=%0d required 1,1", en_n, stop_n);
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [9:0] got, exp;
    clear_logs();
    silent = 1'b1;
    issue(1'b0, 7'h55, 8'h10, 8'hA5, 1'b0);
    exp_q.push_back({2'b10, 8'h00});
    wait_rsp(3 * Tmo, ok, got);
    exp = exp_q.pop_front();
    silent = 1'b0;
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL timeout_rsp: got %h required %h", got, exp); end
    total++;
    // en in SEND_REG, Tmo cycles in WAIT_REG, then stop in STOP.
    if (stop_n != 1 || stop_cyc - en_cyc != int'(Tmo) + 1) begin
      bad++;
      $display("FAIL timeout_latency: got stop=%0d delta=%0d required 1,%0d",
               stop_n, stop_cyc - en_cyc, Tmo + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [9:0] got, exp;
    int n = 0;
    clear_logs();
    issue(1'b0, 7'h55, 8'h11, 8'h5A, 1'b1);
    cmd_rw = 1'b1; cmd_dev = 7'h55; cmd_reg = 8'h22; cmd_wdata = 8'h00;
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h3C});
    while (acc_cyc.size() < 2 && n < 400) begin @(negedge clk); n++; end
    cmd_valid = 1'b0;
    wait_rsp(200, ok, got);
    exp = exp_q.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL b2b_rsp1: got %h required %h", got, exp); end
    wait_rsp(200, ok, got);
    exp = exp_q.pop_front();
    total++;
    if (!ok || got !== exp) begin bad++; $display("FAIL b2b_rsp2: got %h required %h", got, exp); end
    total++;
    // Accept happens in the IDLE cycle after RESP, so ready is seen low two cycles after rsp_valid.
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2 || acc_cyc[1] - rsp_cyc[0] != 2) begin
      bad++;
      $display("FAIL b2b_accept: got acc=%0d rsp=%0d required 2 entries, 2 cycles apart",
               acc_cyc.size(), rsp_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] got;
    int n = 0;
    int stops;
    clear_logs();
    issue(1'b0, 7'h55, 8'h10, 8'hA5, 1'b0);
    while (en_n < 2 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    got = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_en, m_start, m_stop, m_rw, m_addr, m_tx};
    total++;
    if (en_n != 2 || got !== {1'b1, 30'h0}) begin
      bad++; $display("FAIL midreset_outputs: got %h en=%0d required %h en=2", got, en_n, {1'b1, 30'h0});
    end
    rst_n = 1'b1;
    stops = stop_n;
    repeat (20) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || stop_n != stops || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_quiet: got rsp=%0d stops=%0d ready=%b required 0,%0d,1",
               obs_q.size(), stop_n - stops, cmd_ready, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
